// File: rtl/mem_pkg.sv
// Shared definitions for the cache/memory fill engine and the cache controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // Lowest byte-address bit above the in-block word offset.
  function automatic int block_lsb(input int bs);
    return $clog2(bs) + 2;
  endfunction

endpackage

// File: rtl/mem_block_fill_if.sv
// Word-wide request/acknowledge memory bus between the fill engine and main memory.
interface mem_block_fill_if;

  logic [31:0] busaddr;
  logic        busre;
  logic        buswe;
  logic [31:0] buswd;
  logic [31:0] busrd;
  logic        busack;

  modport master (
    output busaddr, busre, buswe, buswd,
    input  busrd, busack
  );

  modport slave (
    input  busaddr, busre, buswe, buswd,
    output busrd, busack
  );

endinterface

// File: rtl/mem_block_fill.sv
// Block fill / word write-through engine: assembles an aligned cache block
// one word per acknowledged beat, or forwards a single store to memory.
module mem_block_fill
  import mem_pkg::*;
#(
  parameter int blocksize = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memread,
  input  logic                    memwrite,
  input  logic [31:0]             a,
  input  logic [31:0]             wd,
  output logic [blocksize*32-1:0] memdata,
  output logic                    valid,
  mem_block_fill_if.master        bus
);

  localparam int lsb = block_lsb(blocksize);
  localparam int cnt_w = lsb - 2;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(blocksize - 1);

  mem_state_t             state_r;
  mem_state_t             state_s;
  logic [cnt_w-1:0]       cnt_r;
  logic [cnt_w-1:0]       cnt_s;
  logic [31:0]            busaddr_r;
  logic [31:0]            busaddr_s;
  logic                   busre_r;
  logic                   busre_s;
  logic                   buswe_r;
  logic                   buswe_s;
  logic [31:0]            buswd_r;
  logic [31:0]            buswd_s;
  logic                   valid_r;
  logic                   valid_s;
  logic [blocksize*32-1:0] memdata_r;
  logic [blocksize-1:0]   slot_we_s;
  logic                   unused_a_s;

  // Byte offset within a word never reaches the word-wide bus.
  assign unused_a_s = ^a[1:0];

  // Next state, beat counter and the next registered bus/handshake values.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    busaddr_s = 32'h0000_0000;
    buswd_s   = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (memwrite) begin
          state_s = WRITE;
        end else if (memread) begin
          state_s = READ;
          cnt_s   = {cnt_w{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (bus.busack) begin
          cnt_s   = cnt_r + cnt_w'(1);
          state_s = (cnt_r == cnt_last) ? DONE : READ;
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (bus.busack) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    busre_s = (state_s == READ);
    buswe_s = (state_s == WRITE);
    valid_s = (state_s == DONE);
    case (state_s)
      READ:    busaddr_s = {a[31:lsb], cnt_s, 2'b00};
      WRITE: begin
        busaddr_s = {a[31:2], 2'b00};
        buswd_s   = wd;
      end
      default: busaddr_s = 32'h0000_0000;
    endcase
  end

  // One write enable per block slot, decoded from the current beat number.
  always_comb begin
    slot_we_s = {blocksize{1'b0}};
    for (int k = 0; k < blocksize; k++) begin
      slot_we_s[k] = (state_r == READ) && bus.busack && (cnt_r == cnt_w'(k));
    end
  end

  // Control state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {cnt_w{1'b0}};
      busaddr_r <= 32'h0000_0000;
      busre_r   <= 1'b0;
      buswe_r   <= 1'b0;
      buswd_r   <= 32'h0000_0000;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      busaddr_r <= busaddr_s;
      busre_r   <= busre_s;
      buswe_r   <= buswe_s;
      buswd_r   <= buswd_s;
      valid_r   <= valid_s;
    end
  end

  // Block register; word 0 lives in the most-significant slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      memdata_r <= {(blocksize*32){1'b0}};
    end else begin
      for (int k = 0; k < blocksize; k++) begin
        if (slot_we_s[k]) begin
          memdata_r[(blocksize-1-k)*32 +: 32] <= bus.busrd;
        end
      end
    end
  end

  assign memdata     = memdata_r;
  assign valid       = valid_r;
  assign bus.busaddr = busaddr_r;
  assign bus.busre   = busre_r;
  assign bus.buswe   = buswe_r;
  assign bus.buswd   = buswd_r;

endmodule

// File: tb/tb_mem_block_fill.sv
// Directed + randomized bench for mem_block_fill; the bench plays main memory
// from a word-addressed model and predicts blocks, bus beats and valid pulses.
module tb_mem_block_fill;

  localparam int bs = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           memread;
  logic           memwrite;
  logic [31:0]    a;
  logic [31:0]    wd;
  logic [bs*32-1:0] memdata;
  logic           valid;

  mem_block_fill_if bus_if ();

  mem_block_fill #(.blocksize(bs)) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .a        (a),
    .wd       (wd),
    .memdata  (memdata),
    .valid    (valid),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  mem_model [logic [31:0]];
  logic [127:0] last_block;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
    return mem_model[wa];
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_busre"}, bus_if.busre, 1'b0);
    chk({tag, "_buswe"}, bus_if.buswe, 1'b0);
    chk({tag, "_memdata"}, memdata, last_block);
  endtask

  // Full aligned block fill; fixed_wait < 0 picks a random wait per beat.
  task automatic do_fill(input logic [31:0] addr, input int fixed_wait);
    logic [31:0]  base;
    logic [127:0] blk;
    int w;
    base = {addr[31:4], 4'h0};
    blk = '0;
    memread = 1'b1;
    a = addr;
    for (int k = 0; k < bs; k++) begin
      w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3, 0));
      for (int j = 0; j <= w; j++) begin
        @(negedge clk);
        chk("fill_busre", bus_if.busre, 1'b1);
        chk("fill_buswe", bus_if.buswe, 1'b0);
        chk("fill_valid", valid, 1'b0);
        chk("fill_busaddr", bus_if.busaddr, base + 32'(4 * k));
        bus_if.busack = (j == w);
        bus_if.busrd  = (j == w) ? mem_word(base + 32'(4 * k)) : $urandom;
      end
      blk = {blk[95:0], mem_word(base + 32'(4 * k))};
    end
    @(negedge clk);
    chk("fill_done_valid", valid, 1'b1);
    chk("fill_done_busre", bus_if.busre, 1'b0);
    chk("fill_block", memdata, blk);
    bus_if.busack = 1'b0;
    memread = 1'b0;
    last_block = blk;
    @(negedge clk);
    idle_checks("fill_after");
  endtask

  // Single-word write-through, optionally with memread also raised.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int waits, input logic with_read);
    memwrite = 1'b1;
    memread = with_read;
    a = addr;
    wd = data;
    for (int j = 0; j <= waits; j++) begin
      @(negedge clk);
      chk("wr_buswe", bus_if.buswe, 1'b1);
      chk("wr_busre", bus_if.busre, 1'b0);
      chk("wr_busaddr", bus_if.busaddr, {addr[31:2], 2'b00});
      chk("wr_buswd", bus_if.buswd, data);
      chk("wr_valid", valid, 1'b0);
      bus_if.busack = (j == waits);
      bus_if.busrd  = $urandom;
    end
    @(negedge clk);
    chk("wr_done_valid", valid, 1'b1);
    chk("wr_done_buswe", bus_if.buswe, 1'b0);
    chk("wr_memdata_kept", memdata, last_block);
    mem_model[{addr[31:2], 2'b00}] = data;
    bus_if.busack = 1'b0;
    memwrite = 1'b0;
    memread = 1'b0;
    @(negedge clk);
    idle_checks("wr_after");
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] w0;
    logic [31:0] w1;
    reset = 1'b1;
    memread = 1'b0;
    memwrite = 1'b0;
    a = 32'h0;
    wd = 32'h0;
    bus_if.busack = 1'b0;
    bus_if.busrd = 32'h0;
    last_block = '0;
    repeat (2) @(negedge clk);
    chk("rst_busaddr", bus_if.busaddr, 32'h0);
    chk("rst_buswd", bus_if.buswd, 32'h0);
    idle_checks("rst");
    reset = 1'b0;

    // Idle with stray acknowledges: nothing must happen.
    for (int i = 0; i < 4; i++) begin
      bus_if.busack = i[0];
      bus_if.busrd = $urandom;
      @(negedge clk);
      chk("idle_busaddr", bus_if.busaddr, 32'h0);
      idle_checks("idle");
    end
    bus_if.busack = 1'b0;

    // Directed fill, zero-wait and two-wait memory.
    for (int k = 0; k < bs; k++) mem_model[32'h1230 + 32'(4 * k)] = 32'hA0 + 32'(k);
    do_fill(32'h0000_1238, 0);
    chk("dir_fill_block", memdata, 128'h000000A0_000000A1_000000A2_000000A3);
    do_fill(32'h0000_1238, 2);
    chk("dir_fill2_block", memdata, 128'h000000A0_000000A1_000000A2_000000A3);

    // Directed writes, then both requests at once.
    do_write(32'h0000_2006, 32'hDEAD_BEEF, 1, 1'b0);
    do_write(32'h0000_3008, 32'h1234_5678, 0, 1'b1);

    // Reset after the second beat of a fill.
    base = 32'h0000_4440;
    memread = 1'b1;
    a = base + 32'h4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstfill_busaddr", bus_if.busaddr, base + 32'(4 * k));
      bus_if.busack = 1'b1;
      bus_if.busrd = mem_word(base + 32'(4 * k));
    end
    @(negedge clk);
    w0 = mem_word(base);
    w1 = mem_word(base + 32'h4);
    chk("rstfill_partial", memdata[127:64], {w0, w1});
    reset = 1'b1;
    memread = 1'b0;
    bus_if.busack = 1'b0;
    @(negedge clk);
    last_block = '0;
    chk("rstfill_busaddr0", bus_if.busaddr, 32'h0);
    idle_checks("rstfill");
    reset = 1'b0;
    @(negedge clk);
    idle_checks("rstfill_idle");
    do_fill(base, 0);

    // Randomized mix of fills and writes against the memory model.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1, 0) == 0) begin
        do_fill({16'h0000, 16'($urandom)} & 32'h0000_00FF, -1);
      end else begin
        do_write({16'h0000, 16'($urandom)} & 32'h0000_00FF, $urandom,
                 int'($urandom_range(2, 0)), 1'($urandom));
      end
    end
    do_fill(32'h0000_0040, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_fill.md
# mem_block_fill

Bus-side fill/write-through engine between the data cache and word-wide main memory. On a cache miss it fetches a full aligned block one word at a time over a request/acknowledge bus and presents the assembled block, with a one-cycle `valid` pulse, to the cache's refill port. On a store it performs a single-word write-through and pulses `valid` when the write has been accepted.

## Interface
- `blocksize`, 4, words per cache block (power of two, ≥2)
- `clk` input 1 — single clock, all state updates on rising edge
- `reset` input 1 — synchronous, active-high
- `memread` input 1 — block fill request from cache controller
- `memwrite` input 1 — word write-through request from cache controller
- `a` input 32 — byte address of the access
- `wd` input 32 — store data for write-through
- `memdata` output blocksize*32 — assembled block, word 0 in the most-significant slot
- `valid` output 1 — one-cycle completion pulse for a fill or write
- `busaddr` output 32 — word address presented to memory
- `busre` output 1 — memory read strobe
- `buswe` output 1 — memory write strobe
- `buswd` output 32 — memory write data
- `busrd` input 32 — memory read data, valid when `busack`=1
- `busack` input 1 — memory accepts/completes current beat this cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: samples requests; `memwrite`=1 → WRITE (priority over read); else `memread`=1 → READ with word counter cleared to 0; else stay.
- READ: `busre`=1, `busaddr` = {a[31:L], cnt, 2'b00}, L = $clog2(blocksize)+2; fill is always aligned, starting at word 0 regardless of a[L-1:2].
- On `busack` in READ: capture `busrd` into slot cnt, where slot k occupies memdata[(blocksize-k)*32-1 : (blocksize-k-1)*32]; cnt increments; after slot blocksize-1 → DONE.
- WRITE: `buswe`=1, `busaddr` = {a[31:2], 2'b00}, `buswd` = `wd`; on `busack` → DONE. `memdata` untouched.
- DONE: `valid`=1 for exactly this cycle, then → IDLE unconditionally.
- `memdata` is registered and holds the last completed block until the next fill overwrites slots; slots written during a fill are visible immediately (no guarantee of consistency before `valid`).
- Requester holds `a`, `wd` and its request stable from assertion until `valid`, and must drop the request in the cycle after `valid`; a request still high in IDLE starts a new transaction.
- `busack` outside READ/WRITE is ignored. `busre` and `buswe` are never both 1.
- cnt width = $clog2(blocksize); it wraps to 0 only via the transition to DONE.

## Timing
- Reset values: state IDLE, cnt 0, `memdata` all zeros, `valid` 0, `busre` 0, `buswe` 0, `busaddr` 0, `buswd` 0.
- Reset asserted mid-fill or mid-write aborts the transaction at the next edge; no `valid` is produced; partial block is cleared.
- Bus strobes are Moore outputs of state; `busaddr` follows cnt registered value.
- Fill latency with `busack`=1 every cycle: request seen in cycle 0, READ cycles 1..blocksize, `valid` in cycle blocksize+1 (5 for blocksize=4). Each wait cycle (`busack`=0) adds one cycle.
- Write latency with immediate ack: WRITE cycle 1, `valid` cycle 2.
- Back-to-back: earliest new request acceptance is the IDLE cycle following DONE.

## Structure
- Shared package `mem_pkg`: `mem_state_t` enum (IDLE, READ, WRITE, DONE) and a `block_lsb(blocksize)` constant function returning L; reused by the cache controller.
- Single module, no sub-modules; block register written via per-slot enable decoded from cnt.

## Test plan
- Reset then idle: all outputs 0; `busack` pulses ignored; no `valid`.
- Fill, a=0x0000_1238, zero-wait memory returning 0xA0,0xA1,0xA2,0xA3 for addresses 0x1230..0x123C → `busaddr` sequence 0x1230,0x1234,0x1238,0x123C, `memdata`=0x000000A0_000000A1_000000A2_000000A3, `valid` in cycle 5 only.
- Fill with 2 wait cycles before each ack → `busaddr` held per beat, `valid` in cycle 13, same block content.
- Write a=0x0000_2006, wd=0xDEAD_BEEF, ack after 1 wait → `buswe`=1, `busaddr`=0x2004, `buswd`=0xDEADBEEF for 2 cycles, `valid` next cycle, `memdata` unchanged.
- `memread` and `memwrite` both 1 in IDLE → WRITE first; no `busre` during it.
- `reset` asserted after second beat of a fill → next cycle IDLE, `memdata`=0, `busre`=0, no `valid`; a following fill completes normally.
